// File: rtl/demux_pkg.sv
// Shared word and index types for the 8:1 bit-select mux and the
// matching 1:8 deserializer on the receive side.
package demux_pkg;

    localparam int DEMUX_WIDTH = 8;
    localparam int DEMUX_SEL_W = $clog2(DEMUX_WIDTH);

    typedef logic [DEMUX_WIDTH-1:0] demux_word_t;
    typedef logic [DEMUX_SEL_W-1:0] demux_idx_t;

endpackage

// File: rtl/bit_pos_counter.sv
// Bit position counter: steps 0..WIDTH-1 on each accepted bit and
// wraps, with synchronous reset and abort.
module bit_pos_counter
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] idx,
    output logic             last
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= last ? '0 : idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/demux1_8_deser.sv
// Serial-to-parallel deserializer: LSB-first bit capture into a partial
// register, with a one-word valid/ready output buffer.
module demux1_8_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] idx
);

    // The top bit never lands here; it goes straight into out_data.
    logic [WIDTH-2:0] partial;
    logic [WIDTH-2:0] partial_next;
    logic             last;
    logic             accept;
    logic             complete;

    assign in_ready = !last || !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !clr;
    assign complete = accept && last;

    bit_pos_counter #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (accept),
        .idx  (idx),
        .last (last)
    );

    always_comb begin
        partial_next = partial;
        if (complete) begin
            partial_next = '0;
        end else if (accept) begin
            for (int k = 0; k < WIDTH - 1; k++) begin
                if (idx == SEL_W'(k)) begin
                    partial_next[k] = in_bit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            partial <= '0;
        end else begin
            partial <= partial_next;
        end
    end

    // A completing word refills the buffer even while it is being drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (complete) begin
            out_data  <= {in_bit, partial};
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux1_8_deser.sv
// Bench for demux1_8_deser: directed scenarios plus randomized traffic
// compared against a bit-count/word-buffer reference model.
module tb_demux1_8_deser;
    import demux_pkg::*;

    localparam int W = DEMUX_WIDTH;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    demux_word_t out_data;
    logic        out_valid;
    logic        out_ready;
    demux_idx_t  idx;

    int n_tests;
    int n_fail;

    // Reference model state
    int          m_cnt;
    demux_word_t m_part;
    demux_word_t m_word;
    logic        m_valid;

    demux1_8_deser dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idx       (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    function automatic logic model_ready();
        return (m_cnt != W - 1) || !m_valid || out_ready;
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        logic acc;
        logic done;
        acc  = in_valid && model_ready();
        done = 1'b0;
        @(posedge clk);
        if (rst) begin
            m_cnt   = 0;
            m_part  = '0;
            m_word  = '0;
            m_valid = 1'b0;
        end else begin
            if (clr) begin
                m_cnt  = 0;
                m_part = '0;
            end else if (acc) begin
                m_part = m_part | (demux_word_t'(in_bit) << m_cnt);
                if (m_cnt == W - 1) begin
                    m_word = m_part;
                    done   = 1'b1;
                    m_cnt  = 0;
                    m_part = '0;
                end else begin
                    m_cnt++;
                end
            end
            if (done) m_valid = 1'b1;
            else if (m_valid && out_ready) m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic send_bits(input demux_word_t w, input int n);
        for (int i = 0; i < n; i++) begin
            in_bit   = w[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 ||
            idx !== 3'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: valid=%b data=%h idx=%0d rdy=%b want 0 00 0 1",
                     out_valid, out_data, idx, in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_bits(8'hA5, 8);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || idx !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_word: valid=%b data=%h idx=%0d want 1 a5 0",
                     out_valid, out_data, idx);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_onehot();
        demux_word_t w;
        out_ready = 1'b1;
        for (int k = 0; k < W; k++) begin
            w = demux_word_t'(1) << k;
            send_bits(w, 8);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== w || out_data[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL onehot_%0d: valid=%b data=%h want 1 %h",
                         k, out_valid, out_data, w);
            end
        end
        tick();
    endtask

    task automatic test_back_pressure();
        demux_word_t w;
        logic bad;
        out_ready = 1'b1;
        send_bits(8'hFF, 8);
        out_ready = 1'b0;
        w   = 8'h3C;
        bad = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            in_bit   = w[i];
            in_valid = 1'b1;
            #1;
            if (in_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_fill: in_ready dropped during positions 0..6, want 1");
        end
        in_bit   = w[W-1];
        in_valid = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || idx !== 3'd7) begin
            n_fail++;
            $display("FAIL bp_stall: rdy=%b idx=%0d want 0 7", in_ready, idx);
        end
        tick();
        tick();
        n_tests++;
        if (out_data !== 8'hFF || out_valid !== 1'b1 || idx !== 3'd7) begin
            n_fail++;
            $display("FAIL bp_hold: data=%h valid=%b idx=%0d want ff 1 7",
                     out_data, out_valid, idx);
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_rdy: rdy=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_data !== 8'h3C || out_valid !== 1'b1 || idx !== 3'd0) begin
            n_fail++;
            $display("FAIL bp_release: data=%h valid=%b idx=%0d want 3c 1 0",
                     out_data, out_valid, idx);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_bits(8'h96, 8);
        out_ready = 1'b0;
        send_bits(8'h69, 7);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h96) begin
            n_fail++;
            $display("FAIL b2b_held: valid=%b data=%h want 1 96", out_valid, out_data);
        end
        out_ready = 1'b1;
        in_bit    = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h69) begin
            n_fail++;
            $display("FAIL b2b_swap: valid=%b data=%h want 1 69", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        send_bits(8'h1F, 5);
        clr      = 1'b1;
        in_bit   = 1'b1;
        in_valid = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (idx !== 3'd0) begin
            n_fail++;
            $display("FAIL clr_idx: idx=%0d want 0", idx);
        end
        send_bits(8'h5A, 8);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL clr_word: valid=%b data=%h want 1 5a", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_bits(8'hC3, 8);
        send_bits(8'h07, 3);
        n_tests++;
        if (out_valid !== 1'b1 || idx !== 3'd3) begin
            n_fail++;
            $display("FAIL rst_mid_pre: valid=%b idx=%0d want 1 3", out_valid, idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 ||
            idx !== 3'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b data=%h idx=%0d rdy=%b want 0 00 0 1",
                     out_valid, out_data, idx, in_ready);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bit    = $urandom_range(0, 1) != 0;
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 400) == 0);
            #1;
            n_tests++;
            if (in_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL rand_rdy c=%0d: rdy=%b want %b", c, in_ready, model_ready());
            end
            tick();
            n_tests++;
            if (out_valid !== m_valid || idx !== demux_idx_t'(m_cnt) ||
                (m_valid && out_data !== m_word)) begin
                n_fail++;
                $display("FAIL rand_out c=%0d: valid=%b idx=%0d data=%h want %b %0d %h",
                         c, out_valid, idx, out_data, m_valid, m_cnt, m_word);
            end
        end
        clr = 1'b0;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        clr       = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_cnt     = 0;
        m_part    = '0;
        m_word    = '0;
        m_valid   = 1'b0;
        #3;
        test_reset();
        test_basic();
        test_onehot();
        test_back_pressure();
        test_back_to_back();
        test_clr();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
